// File: rtl/pc_shot_engine_pkg.sv
// Shared battleship definitions: cell encoding, board geometry and coordinate helpers.
package battleship_pkg;

    localparam int BOARD_N = 5;

    typedef logic [2:0] coord_t;

    // A cell counts as already shot whenever bit 1 is set (MISS or HIT)
    typedef enum logic [1:0] {
        WATER = 2'b00,
        SHIP  = 2'b01,
        MISS  = 2'b10,
        HIT   = 2'b11
    } cell_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PICK,
        ST_PROBE,
        ST_SCAN,
        ST_FIRE,
        ST_DONE
    } shot_state_t;

    // Folds a 3-bit random value onto 0..side-1 with one compare/subtract (side >= 4)
    function automatic coord_t fold_coord(input logic [2:0] raw, input coord_t side);
        return (raw >= side) ? coord_t'(raw - side) : raw;
    endfunction

endpackage

// File: rtl/pc_shot_engine_if.sv
// Bundles the game handshake (FSMgame side) and the board read/write bus (tablero side).
interface pc_shot_engine_if;
    import battleship_pkg::*;

    logic       pc_turn;
    logic [2:0] ships_total;
    coord_t     rd_i;
    coord_t     rd_j;
    logic [1:0] rd_data;
    logic       wr_en;
    coord_t     wr_i;
    coord_t     wr_j;
    logic [1:0] wr_data;
    logic       shot_done;
    logic       shot_hit;
    logic [2:0] hits;
    logic       all_sunk;

    modport master (
        input  pc_turn, ships_total, rd_data,
        output rd_i, rd_j, wr_en, wr_i, wr_j, wr_data,
               shot_done, shot_hit, hits, all_sunk
    );

    modport slave (
        output pc_turn, ships_total, rd_data,
        input  rd_i, rd_j, wr_en, wr_i, wr_j, wr_data,
               shot_done, shot_hit, hits, all_sunk
    );

endinterface

// File: rtl/pc_shot_engine_lfsr8.sv
// 8-bit Fibonacci LFSR, taps 8,6,5,4 (maximal length, never reaches zero from a non-zero seed).
module lfsr8 #(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic [7:0] q
);

    // Shift left, feeding the XOR of the tap bits into bit 0
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= SEED;
        end else if (en) begin
            q <= {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
        end
    end

endmodule

// File: rtl/pc_shot_engine.sv
// Computer-opponent firing stage: picks a random unshot cell on the player's board,
// falls back to a linear scan after repeated collisions, and writes the shot result.
module pc_shot_engine
    import battleship_pkg::*;
#(
    parameter int         BOARD_N   = 5,
    parameter int         MAX_TRIES = 8,
    parameter logic [7:0] LFSR_SEED = 8'hA5
) (
    input  logic              clk,
    input  logic              rst,
    pc_shot_engine_if.master  bus
);

    localparam coord_t     SIDE     = coord_t'(BOARD_N);
    localparam coord_t     LAST     = coord_t'(BOARD_N - 1);
    localparam logic [3:0] LAST_TRY = 4'(MAX_TRIES - 1);

    shot_state_t state, state_nxt;
    logic [7:0]  lfsr;
    logic        pc_turn_q;
    coord_t      cur_i, cur_j, cur_i_nxt, cur_j_nxt;
    coord_t      cand_i, cand_j;
    logic [3:0]  tries, tries_nxt;
    logic        shot_hit_q, shot_hit_nxt;
    logic [2:0]  hits_q, hits_nxt;
    logic        all_sunk_q;
    logic        turn_edge;
    logic        cell_shot;
    logic        unused_lfsr_msbs;

    // Free-running draw source; it steps every cycle so draws depend on player timing
    lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk (clk),
        .rst (rst),
        .en  (1'b1),
        .q   (lfsr)
    );

    assign unused_lfsr_msbs = ^lfsr[7:6];

    assign cand_i    = fold_coord(lfsr[2:0], SIDE);
    assign cand_j    = fold_coord(lfsr[5:3], SIDE);
    assign turn_edge = bus.pc_turn & ~pc_turn_q;
    assign cell_shot = bus.rd_data[1];

    assign bus.rd_i     = cur_i;
    assign bus.rd_j     = cur_j;
    assign bus.wr_i     = cur_i;
    assign bus.wr_j     = cur_j;
    assign bus.shot_hit = shot_hit_q;
    assign bus.hits     = hits_q;
    assign bus.all_sunk = all_sunk_q;

    // Next-state logic: random probing, scan fallback, single write, single done pulse
    always_comb begin
        state_nxt     = state;
        cur_i_nxt     = cur_i;
        cur_j_nxt     = cur_j;
        tries_nxt     = tries;
        shot_hit_nxt  = shot_hit_q;
        hits_nxt      = hits_q;
        bus.wr_en     = 1'b0;
        bus.wr_data   = MISS;
        bus.shot_done = 1'b0;

        case (state)
            ST_IDLE: begin
                if (turn_edge && !all_sunk_q) begin
                    state_nxt = ST_PICK;
                end
            end

            ST_PICK: begin
                cur_i_nxt = cand_i;
                cur_j_nxt = cand_j;
                tries_nxt = '0;
                state_nxt = ST_PROBE;
            end

            ST_PROBE: begin
                if (!cell_shot) begin
                    state_nxt = ST_FIRE;
                end else if (tries < LAST_TRY) begin
                    tries_nxt = tries + 4'd1;
                    cur_i_nxt = cand_i;
                    cur_j_nxt = cand_j;
                end else begin
                    cur_i_nxt = '0;
                    cur_j_nxt = '0;
                    state_nxt = ST_SCAN;
                end
            end

            ST_SCAN: begin
                if (!cell_shot) begin
                    state_nxt = ST_FIRE;
                end else if (cur_j == LAST) begin
                    cur_j_nxt = '0;
                    if (cur_i == LAST) begin
                        cur_i_nxt    = '0;
                        shot_hit_nxt = 1'b0;
                        state_nxt    = ST_DONE;
                    end else begin
                        cur_i_nxt = cur_i + 3'd1;
                    end
                end else begin
                    cur_j_nxt = cur_j + 3'd1;
                end
            end

            ST_FIRE: begin
                bus.wr_en = 1'b1;
                if (bus.rd_data == SHIP) begin
                    bus.wr_data  = HIT;
                    shot_hit_nxt = 1'b1;
                    hits_nxt     = (hits_q == 3'd7) ? 3'd7 : hits_q + 3'd1;
                end else begin
                    shot_hit_nxt = 1'b0;
                end
                state_nxt = ST_DONE;
            end

            ST_DONE: begin
                bus.shot_done = 1'b1;
                state_nxt     = ST_IDLE;
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State registers; all_sunk is refreshed on entry to DONE so it rises with shot_done
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            pc_turn_q  <= 1'b0;
            cur_i      <= '0;
            cur_j      <= '0;
            tries      <= '0;
            shot_hit_q <= 1'b0;
            hits_q     <= '0;
            all_sunk_q <= 1'b0;
        end else begin
            state      <= state_nxt;
            pc_turn_q  <= bus.pc_turn;
            cur_i      <= cur_i_nxt;
            cur_j      <= cur_j_nxt;
            tries      <= tries_nxt;
            shot_hit_q <= shot_hit_nxt;
            hits_q     <= hits_nxt;
            if (state_nxt == ST_DONE) begin
                all_sunk_q <= (hits_nxt == bus.ships_total) && (bus.ships_total != 3'd0);
            end
        end
    end

endmodule

// File: tb/tb_pc_shot_engine.sv
// Directed bench for pc_shot_engine: a 5x5 board model answers reads and absorbs writes,
// and an independent LFSR model lets shots be timed onto chosen draws.
module tb_pc_shot_engine;

    localparam logic [1:0] C_WATER = 2'b00;
    localparam logic [1:0] C_SHIP  = 2'b01;
    localparam logic [1:0] C_MISS  = 2'b10;
    localparam logic [1:0] C_HIT   = 2'b11;
    localparam logic [7:0] SEED    = 8'hA5;
    localparam int         TRIES   = 8;

    logic       clk;
    logic       rst;
    logic [1:0] board [8][8];
    logic [7:0] lfsr_m;
    int         checks;
    int         fails;
    int         wr_count;
    int         done_count;
    int         last_wi, last_wj;
    logic [1:0] last_wd;
    int         lat, w0, d0, di, dj, d1i, d1j, d2i, d2j;
    bit         found, ok;
    logic [7:0] x;

    pc_shot_engine_if bus();

    pc_shot_engine dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.rd_data = board[bus.rd_i][bus.rd_j];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    function automatic int draw_i(input logic [7:0] v);
        return int'(v[2:0]) % 5;
    endfunction

    function automatic int draw_j(input logic [7:0] v);
        return int'(v[5:3]) % 5;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: capture any write mid-cycle, commit it to the board just after the edge
    task automatic tick();
        logic       pend;
        logic [2:0] pi, pj;
        logic [1:0] pd;
        @(negedge clk);
        pend = bus.wr_en;
        pi   = bus.wr_i;
        pj   = bus.wr_j;
        pd   = bus.wr_data;
        @(posedge clk);
        lfsr_m = rst ? SEED : lfsr_step(lfsr_m);
        #1;
        if (pend === 1'b1) begin
            board[pi][pj] = pd;
            wr_count++;
            last_wi = int'(pi);
            last_wj = int'(pj);
            last_wd = pd;
        end
        if (bus.shot_done === 1'b1) done_count++;
    endtask

    task automatic clear_board(input logic [1:0] v);
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++)
                board[i][j] = v;
    endtask

    task automatic search_fail(input string tag);
        fails++;
        $error("[TB] FAIL %s: no suitable draw found within bound", tag);
    endtask

    // Tick until raising pc_turn now would make PICK latch the wanted (or any unshot) cell
    task automatic find_draw(input int want_i, input int want_j, output int oi, output int oj, output bit hit);
        logic [7:0] nx;
        hit = 0; oi = 0; oj = 0;
        for (int n = 0; n < 400 && !hit; n++) begin
            tick();
            nx = lfsr_step(lfsr_m);
            oi = draw_i(nx);
            oj = draw_j(nx);
            if ((want_i < 0 || (oi == want_i && oj == want_j)) && board[oi][oj][1] == 1'b0) hit = 1;
        end
    endtask

    // Pulse pc_turn for one cycle and wait (bounded) for shot_done
    task automatic applyStimulus(input int limit, output int latency);
        bus.pc_turn = 1'b1;
        latency = 0;
        for (int n = 1; n <= limit; n++) begin
            tick();
            if (n == 1) bus.pc_turn = 1'b0;
            if (bus.shot_done === 1'b1) begin
                latency = n;
                break;
            end
        end
    endtask

    initial begin
        checks = 0; fails = 0; wr_count = 0; done_count = 0;
        last_wi = 0; last_wj = 0; last_wd = 2'b00;
        lfsr_m = SEED;
        rst = 1'b1;
        bus.pc_turn = 1'b0;
        bus.ships_total = 3'd0;
        clear_board(C_WATER);
        tick();
        tick();

        // Reset state
        checkOutput("rst_wr_en", bus.wr_en, 1'b0);
        checkOutput("rst_shot_done", bus.shot_done, 1'b0);
        checkOutput("rst_shot_hit", bus.shot_hit, 1'b0);
        checkOutput("rst_hits", bus.hits, 3'd0);
        checkOutput("rst_all_sunk", bus.all_sunk, 1'b0);
        checkOutput("rst_rd_i", bus.rd_i, 3'd0);
        checkOutput("rst_rd_j", bus.rd_j, 3'd0);
        rst = 1'b0;

        // 1: first draw lands on the ship at (2,3)
        bus.ships_total = 3'd5;
        clear_board(C_WATER);
        board[2][3] = C_SHIP;
        find_draw(2, 3, di, dj, found);
        if (!found) search_fail("t1_search");
        w0 = wr_count;
        applyStimulus(60, lat);
        checkOutput("t1_latency", lat, 4);
        checkOutput("t1_writes", wr_count - w0, 1);
        checkOutput("t1_wr_i", last_wi, 2);
        checkOutput("t1_wr_j", last_wj, 3);
        checkOutput("t1_wr_data", last_wd, C_HIT);
        checkOutput("t1_shot_hit", bus.shot_hit, 1'b1);
        checkOutput("t1_hits", bus.hits, 3'd1);
        checkOutput("t1_all_sunk", bus.all_sunk, 1'b0);

        // 2: first draw on a MISS cell, second draw on WATER
        clear_board(C_WATER);
        found = 0;
        for (int n = 0; n < 400 && !found; n++) begin
            tick();
            x = lfsr_step(lfsr_m);
            d1i = draw_i(x); d1j = draw_j(x);
            x = lfsr_step(x);
            d2i = draw_i(x); d2j = draw_j(x);
            found = (d1i != d2i) || (d1j != d2j);
        end
        if (!found) search_fail("t2_search");
        board[d1i][d1j] = C_MISS;
        w0 = wr_count;
        applyStimulus(60, lat);
        checkOutput("t2_latency", lat, 5);
        checkOutput("t2_writes", wr_count - w0, 1);
        checkOutput("t2_wr_i", last_wi, d2i);
        checkOutput("t2_wr_j", last_wj, d2j);
        checkOutput("t2_wr_data", last_wd, C_MISS);
        checkOutput("t2_miss_cell_kept", board[d1i][d1j], C_MISS);
        checkOutput("t2_shot_hit", bus.shot_hit, 1'b0);
        checkOutput("t2_hits", bus.hits, 3'd1);

        // 3: only (4,4) unshot and no random draw reaches it -> full retries then scan
        clear_board(C_MISS);
        board[4][4] = C_WATER;
        found = 0;
        for (int n = 0; n < 400 && !found; n++) begin
            tick();
            x = lfsr_m;
            ok = 1;
            for (int k = 0; k < TRIES; k++) begin
                x = lfsr_step(x);
                if (draw_i(x) == 4 && draw_j(x) == 4) ok = 0;
            end
            found = ok;
        end
        if (!found) search_fail("t3_search");
        w0 = wr_count;
        applyStimulus(60, lat);
        checkOutput("t3_latency", lat, 36);
        checkOutput("t3_writes", wr_count - w0, 1);
        checkOutput("t3_wr_i", last_wi, 4);
        checkOutput("t3_wr_j", last_wj, 4);
        checkOutput("t3_wr_data", last_wd, C_MISS);

        // 4: two hits against ships_total=2 -> defeat, further turns ignored
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.ships_total = 3'd2;
        clear_board(C_WATER);
        find_draw(-1, -1, di, dj, found);
        if (!found) search_fail("t4a_search");
        board[di][dj] = C_SHIP;
        applyStimulus(60, lat);
        checkOutput("t4a_latency", lat, 4);
        checkOutput("t4a_hits", bus.hits, 3'd1);
        checkOutput("t4a_all_sunk", bus.all_sunk, 1'b0);
        find_draw(-1, -1, di, dj, found);
        if (!found) search_fail("t4b_search");
        board[di][dj] = C_SHIP;
        applyStimulus(60, lat);
        checkOutput("t4b_latency", lat, 4);
        checkOutput("t4b_hits", bus.hits, 3'd2);
        checkOutput("t4b_all_sunk", bus.all_sunk, 1'b1);
        tick();
        w0 = wr_count;
        d0 = done_count;
        applyStimulus(12, lat);
        checkOutput("t4c_no_done", lat, 0);
        checkOutput("t4c_no_write", wr_count - w0, 0);
        checkOutput("t4c_done_count", done_count - d0, 0);

        // 5: pc_turn held high gives one shot; ships_total=0 never reports defeat
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.ships_total = 3'd0;
        clear_board(C_WATER);
        tick();
        w0 = wr_count;
        d0 = done_count;
        bus.pc_turn = 1'b1;
        for (int n = 0; n < 20; n++) tick();
        bus.pc_turn = 1'b0;
        tick();
        checkOutput("t5a_done_count", done_count - d0, 1);
        checkOutput("t5a_writes", wr_count - w0, 1);
        checkOutput("t5a_all_sunk", bus.all_sunk, 1'b0);
        // second rising edge arrives while the shot is in PROBE
        clear_board(C_WATER);
        tick();
        w0 = wr_count;
        d0 = done_count;
        bus.pc_turn = 1'b1;
        tick();
        bus.pc_turn = 1'b0;
        tick();
        bus.pc_turn = 1'b1;
        tick();
        bus.pc_turn = 1'b0;
        for (int n = 0; n < 12; n++) tick();
        checkOutput("t5b_done_count", done_count - d0, 1);
        checkOutput("t5b_writes", wr_count - w0, 1);

        // 6: reset while in PROBE aborts the shot before any write
        bus.ships_total = 3'd5;
        clear_board(C_WATER);
        find_draw(-1, -1, di, dj, found);
        if (!found) search_fail("t6a_search");
        board[di][dj] = C_SHIP;
        applyStimulus(60, lat);
        checkOutput("t6a_hits", bus.hits, 3'd1);
        find_draw(-1, -1, di, dj, found);
        if (!found) search_fail("t6b_search");
        board[di][dj] = C_SHIP;
        w0 = wr_count;
        d0 = done_count;
        bus.pc_turn = 1'b1;
        tick();
        bus.pc_turn = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        checkOutput("t6_wr_en", bus.wr_en, 1'b0);
        checkOutput("t6_hits", bus.hits, 3'd0);
        checkOutput("t6_shot_hit", bus.shot_hit, 1'b0);
        rst = 1'b0;
        // seed check: a shot started right away must draw from step(A5) = 4A -> (2,1)
        clear_board(C_WATER);
        applyStimulus(60, lat);
        checkOutput("t6_seed_latency", lat, 4);
        checkOutput("t6_seed_wr_i", last_wi, 2);
        checkOutput("t6_seed_wr_j", last_wj, 1);
        checkOutput("t6_writes", wr_count - w0, 1);
        checkOutput("t6_done_count", done_count - d0, 1);

        // board cell of the aborted shot untouched across the reset
        board[di][dj] = C_SHIP;
        w0 = wr_count;
        for (int n = 0; n < 5; n++) tick();
        checkOutput("t6_board_kept", board[di][dj], C_SHIP);
        checkOutput("t6_idle_no_write", wr_count - w0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
